// File: rtl/alu_arbiter_ctrl_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter_ctrl.
// slave: the arbiter itself; master: the surrounding requesters, ALU and consumer.
interface alu_arbiter_ctrl_if;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req0_cin;
    logic       req1_cin;
    logic [2:0] req0_ctrl;
    logic [2:0] req1_ctrl;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [4:0] rsp_data;
    logic       busy;
    logic [7:0] op_count;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_cin, req1_cin, req0_ctrl, req1_ctrl,
        input  alu_out, alu_cout, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_cin, alu_ctrl,
        output rsp_valid, rsp_id, rsp_data, busy, op_count
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_cin, req1_cin, req0_ctrl, req1_ctrl,
        output alu_out, alu_cout, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_cin, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_data, busy, op_count
    );
endinterface

// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin arbiter in front of a shared combinational 4-bit ALU.
// Accepted operands are held on the ALU for HOLD_CYCLES cycles, then the result is
// captured and offered on a valid/ready response channel.
module alu_arbiter_ctrl #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic       alu_cin_q, alu_cin_d;
    logic [2:0] alu_ctrl_q, alu_ctrl_d;
    logic [4:0] rsp_data_q, rsp_data_d;
    logic [7:0] op_count_q, op_count_d;

    logic       grant_any;
    logic       grant_id;
    logic       accept;

    // Round-robin pick: the pointer's requester wins a tie, a lone requester always wins.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (!ptr_q) begin
            grant_id = bus.req0_valid ? 1'b0 : 1'b1;
        end else begin
            grant_id = bus.req1_valid ? 1'b1 : 1'b0;
        end
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_data_d = rsp_data_q;
        op_count_d = op_count_q;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    accept     = 1'b1;
                    owner_d    = grant_id;
                    alu_a_d    = grant_id ? bus.req1_a    : bus.req0_a;
                    alu_b_d    = grant_id ? bus.req1_b    : bus.req0_b;
                    alu_cin_d  = grant_id ? bus.req1_cin  : bus.req0_cin;
                    alu_ctrl_d = grant_id ? bus.req1_ctrl : bus.req0_ctrl;
                    cnt_d      = HoldInit;
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d = {bus.alu_cout, bus.alu_out};
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // Fairness advances only on a completed response, not on accept.
                if (bus.rsp_ready) begin
                    ptr_d      = ~ptr_q;
                    op_count_d = op_count_q + 8'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= 4'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_cin_q  <= 1'b0;
            alu_ctrl_q <= 3'd0;
            rsp_data_q <= 5'd0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_ctrl_q <= alu_ctrl_d;
            rsp_data_q <= rsp_data_d;
            op_count_q <= op_count_d;
        end
    end

    // Ready is gated by rst_n so a held request cannot see ready while reset is low.
    assign bus.req0_ready = rst_n & accept & ~grant_id;
    assign bus.req1_ready = rst_n & accept & grant_id;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_cin    = alu_cin_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = owner_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl: one instance with HOLD_CYCLES=1, one with 4,
// each driving a small behavioural ALU.
module tb_alu_arbiter_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k;

    always #5 clk = ~clk;

    alu_arbiter_ctrl_if bus1();
    alu_arbiter_ctrl_if bus4();

    alu_arbiter_ctrl #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_arbiter_ctrl #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Simple ALU: 0 add, 1 and, 2 or, 3 xor, others pass a.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin, input logic [2:0] ctrl);
        case (ctrl)
            3'd0:    alu_f = {1'b0, a} + {1'b0, b} + {4'd0, cin};
            3'd1:    alu_f = {1'b0, a & b};
            3'd2:    alu_f = {1'b0, a | b};
            3'd3:    alu_f = {1'b0, a ^ b};
            default: alu_f = {1'b0, a};
        endcase
    endfunction

    assign {bus1.alu_cout, bus1.alu_out} = alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_cin,
                                                 bus1.alu_ctrl);
    assign {bus4.alu_cout, bus4.alu_out} = alu_f(bus4.alu_a, bus4.alu_b, bus4.alu_cin,
                                                 bus4.alu_ctrl);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.rsp_ready = 0;
        bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_cin = 0; bus1.req0_ctrl = 0;
        bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_cin = 0; bus1.req1_ctrl = 0;
        bus4.req0_valid = 0; bus4.req1_valid = 0; bus4.rsp_ready = 0;
        bus4.req0_a = 0; bus4.req0_b = 0; bus4.req0_cin = 0; bus4.req0_ctrl = 0;
        bus4.req1_a = 0; bus4.req1_b = 0; bus4.req1_cin = 0; bus4.req1_ctrl = 0;

        // Reset state, including no ready while reset is held.
        repeat (2) @(negedge clk);
        bus1.req0_valid = 1;
        #1 chk("rst_ready0", bus1.req0_ready, 0);
        chk("rst_busy", bus1.busy, 0);
        bus1.req0_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", bus1.rsp_valid, 0);
        chk("rst_rsp_id", bus1.rsp_id, 0);
        chk("rst_rsp_data", bus1.rsp_data, 0);
        chk("rst_alu", {bus1.alu_a, bus1.alu_b, bus1.alu_cin, bus1.alu_ctrl}, 0);
        chk("rst_op_count", bus1.op_count, 0);

        // Single op: 8 + 1 + 0 = 9.
        bus1.req0_a = 4'd8; bus1.req0_b = 4'd1; bus1.req0_cin = 0; bus1.req0_ctrl = 3'd0;
        bus1.rsp_ready = 1; bus1.req0_valid = 1;
        #1 chk("op1_ready0", bus1.req0_ready, 1);
        chk("op1_ready1", bus1.req1_ready, 0);
        @(negedge clk);
        bus1.req0_valid = 0;
        chk("op1_alu_a", bus1.alu_a, 8);
        chk("op1_alu_b", bus1.alu_b, 1);
        chk("op1_busy", bus1.busy, 1);
        chk("op1_no_rsp_yet", bus1.rsp_valid, 0);
        @(negedge clk);
        chk("op1_rsp_valid", bus1.rsp_valid, 1);
        chk("op1_rsp_id", bus1.rsp_id, 0);
        chk("op1_rsp_data", bus1.rsp_data, 5'd9);
        @(negedge clk);
        chk("op1_rsp_drop", bus1.rsp_valid, 0);
        chk("op1_count", bus1.op_count, 1);
        chk("op1_idle", bus1.busy, 0);

        // Reset in the middle of DRIVE: everything clears, no response follows.
        bus1.req0_a = 4'd5; bus1.req0_b = 4'd3; bus1.req0_valid = 1;
        @(negedge clk);
        bus1.req0_valid = 0;
        chk("rd_busy_before", bus1.busy, 1);
        chk("rd_alu_a_before", bus1.alu_a, 5);
        rst_n = 1'b0;
        #1 chk("rd_busy", bus1.busy, 0);
        chk("rd_alu", {bus1.alu_a, bus1.alu_b, bus1.alu_cin, bus1.alu_ctrl}, 0);
        chk("rd_op_count", bus1.op_count, 0);
        chk("rd_rsp", {bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rd_no_rsp", bus1.rsp_valid, 0);
        end
        chk("rd_count_after", bus1.op_count, 0);

        // Contention: both requesters held valid, winners alternate 0,1,0,1.
        bus1.req0_a = 4'd3; bus1.req0_b = 4'd4; bus1.req0_cin = 0; bus1.req0_ctrl = 3'd0;
        bus1.req1_a = 4'd5; bus1.req1_b = 4'd6; bus1.req1_cin = 0; bus1.req1_ctrl = 3'd3;
        bus1.rsp_ready = 1;
        bus1.req0_valid = 1; bus1.req1_valid = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!(bus1.req0_ready || bus1.req1_ready) && k < 8) begin
                @(negedge clk);
                k++;
            end
            chk("cont_grant", {bus1.req1_ready, bus1.req0_ready}, (i % 2) ? 2 : 1);
            k = 0;
            @(negedge clk);
            while (!bus1.rsp_valid && k < 8) begin
                @(negedge clk);
                k++;
            end
            chk("cont_id", bus1.rsp_id, i % 2);
            chk("cont_data", bus1.rsp_data, (i % 2) ? 3 : 7);
            @(negedge clk);
        end
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        chk("cont_count", bus1.op_count, 4);

        // Backpressure: response stalls 5 cycles while req0 waits.
        bus1.rsp_ready = 0;
        bus1.req1_a = 4'd2; bus1.req1_b = 4'd2; bus1.req1_ctrl = 3'd0; bus1.req1_valid = 1;
        #1 chk("bp_accept", bus1.req1_ready, 1);
        @(negedge clk);
        bus1.req1_valid = 0;
        bus1.req0_a = 4'd1; bus1.req0_b = 4'd1; bus1.req0_ctrl = 3'd0; bus1.req0_valid = 1;
        #1 chk("bp_drive_noready", bus1.req0_ready, 0);
        @(negedge clk);
        repeat (5) begin
            chk("bp_valid", bus1.rsp_valid, 1);
            chk("bp_data", bus1.rsp_data, 4);
            chk("bp_id", bus1.rsp_id, 1);
            chk("bp_noready", bus1.req0_ready, 0);
            chk("bp_alu_a", bus1.alu_a, 2);
            @(negedge clk);
        end
        bus1.rsp_ready = 1;
        @(negedge clk);
        chk("bp_released", bus1.rsp_valid, 0);
        chk("bp_count", bus1.op_count, 5);
        chk("bp_next_accept", bus1.req0_ready, 1);
        @(negedge clk);
        bus1.req0_valid = 0;
        chk("bp_next_alu_a", bus1.alu_a, 1);
        @(negedge clk);
        chk("bp_next_data", bus1.rsp_data, 2);
        chk("bp_next_id", bus1.rsp_id, 0);
        @(negedge clk);
        chk("bp_count2", bus1.op_count, 6);

        // HOLD_CYCLES=4: 8 + 1 + 1 = 10, response exactly 5 cycles after accept.
        bus4.req0_a = 4'd8; bus4.req0_b = 4'd1; bus4.req0_cin = 1; bus4.req0_ctrl = 3'd0;
        bus4.rsp_ready = 1; bus4.req0_valid = 1;
        #1 chk("h4_accept", bus4.req0_ready, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus4.req0_valid = 0;
            chk("h4_wait", bus4.rsp_valid, 0);
            chk("h4_alu_a", bus4.alu_a, 8);
        end
        @(negedge clk);
        chk("h4_rsp_valid", bus4.rsp_valid, 1);
        chk("h4_rsp_data", bus4.rsp_data, 5'h0A);
        @(negedge clk);
        chk("h4_done", bus4.rsp_valid, 0);
        chk("h4_count", bus4.op_count, 1);

        // Ctrl pass-through and op_count wrap (250 more ops brings the total to 256).
        bus1.req0_a = 4'd8; bus1.req0_b = 4'd1; bus1.req0_cin = 0; bus1.rsp_ready = 1;
        for (int i = 0; i < 250; i++) begin
            bus1.req0_ctrl = 3'(i % 8);
            bus1.req0_valid = 1;
            @(negedge clk);
            bus1.req0_valid = 0;
            if (i < 8) chk("ctrl_pass", bus1.alu_ctrl, i % 8);
            @(negedge clk);
            @(negedge clk);
            if (i == 248) chk("cnt_255", bus1.op_count, 255);
        end
        chk("cnt_wrap", bus1.op_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter_ctrl.md
ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1, number of cycles ALU operands are held before result capture (legal 1..15).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports reqN_valid (N=0,1), input, 1, requester N presents an operation.
REQ-005 SHALL have ports reqN_ready (N=0,1), output, 1, operation from requester N accepted this cycle.
REQ-006 SHALL have ports reqN_a, reqN_b (N=0,1), input, 4, operands.
REQ-007 SHALL have ports reqN_cin, input, 1 and reqN_ctrl, input, 3, carry-in and ALU opcode (opaque to this block).
REQ-008 SHALL have ports alu_a, alu_b, output, 4 and alu_cin, output, 1 and alu_ctrl, output, 3, registered drive to the shared 4-bit ALU.
REQ-009 SHALL have ports alu_out, input, 4 and alu_cout, input, 1, combinational ALU result.
REQ-010 SHALL have port rsp_valid, output, 1, result available.
REQ-011 SHALL have port rsp_ready, input, 1, consumer takes result.
REQ-012 SHALL have port rsp_id, output, 1, index of requester owning the result.
REQ-013 SHALL have port rsp_data, output, 5, {cout, out} captured from ALU.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port op_count, output, 8, completed-operation count.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, RESP.
REQ-017 IDLE: if any reqN_valid, SHALL assert reqN_ready for exactly one winner that cycle, latch its a/b/cin/ctrl plus id into alu_* and owner registers, load hold counter with HOLD_CYCLES-1, go DRIVE.
REQ-018 Arbitration SHALL be round-robin: priority pointer selects first-checked requester; both valid -> pointer's requester wins; only one valid -> it wins regardless of pointer.
REQ-019 Pointer SHALL move to the other requester after every completed response handshake, not on accept.
REQ-020 reqN_ready SHALL be low in DRIVE and RESP; requests there are not accepted and not lost (requester holds valid).
REQ-021 DRIVE: counter SHALL decrement each cycle; on the cycle counter is 0, SHALL capture alu_out/alu_cout into rsp_data and go RESP.
REQ-022 Latency: accept in cycle T -> rsp_valid high in cycle T+HOLD_CYCLES+1.
REQ-023 RESP: rsp_valid high, rsp_id and rsp_data stable until rsp_ready sampled high; then go IDLE, rsp_valid low next cycle, op_count increments.
REQ-024 rsp_ready high in first RESP cycle SHALL complete handshake that cycle; rsp_ready outside RESP SHALL be ignored.
REQ-025 alu_* outputs SHALL hold last latched values in IDLE and RESP; change only on accept.
REQ-026 op_count SHALL wrap 255 -> 0.
REQ-027 Peak throughput SHALL be one operation per HOLD_CYCLES+2 cycles (next accept earliest the cycle after handshake).

Reset
REQ-028 rst_n low SHALL immediately force IDLE, pointer=0, rsp_valid=0, reqN_ready=0, rsp_id=0, rsp_data=0, alu_*=0, busy=0, op_count=0.
REQ-029 Reset during DRIVE or RESP SHALL discard the pending operation with no response and no count increment.

Verification
REQ-030 Single op: req0 a=8,b=1,cin=0,ctrl=000, rsp_ready=1, HOLD_CYCLES=1 -> ready in T, alu_a=8/alu_b=1 in T+1, rsp_valid T+2, rsp_id=0, rsp_data equals {alu_cout,alu_out} at capture, op_count=1.
REQ-031 Contention: req0,req1 valid together after reset -> req0 served first, req1 second, then alternate for 4 ops (ids 0,1,0,1).
REQ-032 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id constant, reqN_ready low, no new ALU drive.
REQ-033 HOLD_CYCLES=4: accept T -> rsp_valid exactly T+5; capture reflects operands held 4 cycles.
REQ-034 Reset asserted in DRIVE -> all outputs zero at once, no rsp_valid after release, op_count unchanged at 0.
REQ-035 256 completed ops -> op_count reads 0; all 8 ctrl codes 000..111 with a=8,b=1 pass through unchanged to alu_ctrl.
